// File: rtl/pixel_shuffle_pkg.sv
// Shared constants, FSM encoding and frame-size helpers for the pixel shuffle stream.
package pixel_shuffle_pkg;

  localparam logic MODE_SHUFFLE   = 1'b0;
  localparam logic MODE_UNSHUFFLE = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  function automatic int frame_elems(input int c_out, input int r, input int h_in, input int w_in);
    return c_out * r * r * h_in * w_in;
  endfunction

  // A single-element frame still needs a one-bit address.
  function automatic int addr_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pixel_shuffle_addr_gen.sv
// Nested wrap-counter source-address generator for shuffle / unshuffle read order.
module pixel_shuffle_addr_gen
  import pixel_shuffle_pkg::*;
#(
  parameter int R     = 2,
  parameter int C_OUT = 1,
  parameter int H_IN  = 2,
  parameter int W_IN  = 2,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mode_i,
  input  logic          clear_i,
  input  logic          step_i,
  output logic [AW-1:0] addr_o,
  output logic          last_o
);

  localparam int LV = 5;
  localparam int HW = H_IN * W_IN;
  localparam int RR = R * R;

  // Levels listed innermost first; shuffle walks c>h>i>w>j, unshuffle walks c>i>j>h>w.
  localparam int LIM_S [LV] = '{R, W_IN, R, H_IN, C_OUT};
  localparam int STR_S [LV] = '{HW, 1, R * HW, W_IN, RR * HW};
  localparam int LIM_U [LV] = '{W_IN, H_IN, R, R, C_OUT};
  localparam int STR_U [LV] = '{R, RR * W_IN, 1, W_IN * R, RR * HW};

  logic [AW-1:0] cnt_q  [LV];
  logic [AW-1:0] cnt_d  [LV];
  logic [AW-1:0] base_q [LV];
  logic [AW-1:0] base_d [LV];
  logic [AW-1:0] max_v  [LV];
  logic [AW-1:0] str_v  [LV];
  logic [LV-1:0] at_max;
  logic          carry_done;

  always_comb begin
    for (int k = 0; k < LV; k++) begin
      max_v[k]  = (mode_i == MODE_UNSHUFFLE) ? AW'(LIM_U[k] - 1) : AW'(LIM_S[k] - 1);
      str_v[k]  = (mode_i == MODE_UNSHUFFLE) ? AW'(STR_U[k]) : AW'(STR_S[k]);
      at_max[k] = (cnt_q[k] == max_v[k]);
    end
  end

  // base_q[k] holds the address contribution of level k and everything above it,
  // so an increment only needs one add and a copy into the wrapped inner levels.
  always_comb begin
    cnt_d      = cnt_q;
    base_d     = base_q;
    carry_done = 1'b0;
    if (clear_i) begin
      for (int k = 0; k < LV; k++) begin
        cnt_d[k]  = '0;
        base_d[k] = '0;
      end
    end else if (step_i) begin
      for (int k = 0; k < LV; k++) begin
        if (!carry_done && !at_max[k]) begin
          cnt_d[k]  = cnt_q[k] + AW'(1);
          base_d[k] = base_q[k] + str_v[k];
          for (int m = 0; m < k; m++) begin
            cnt_d[m]  = '0;
            base_d[m] = base_q[k] + str_v[k];
          end
          carry_done = 1'b1;
        end
      end
      if (!carry_done) begin
        for (int k = 0; k < LV; k++) begin
          cnt_d[k]  = '0;
          base_d[k] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < LV; k++) begin
        cnt_q[k]  <= '0;
        base_q[k] <= '0;
      end
    end else begin
      cnt_q  <= cnt_d;
      base_q <= base_d;
    end
  end

  assign addr_o = base_q[0];
  assign last_o = &at_max;

endmodule

// File: rtl/pixel_shuffle_stream.sv
// Single-buffer streaming pixel shuffle: fill one frame, then drain it in
// depth-to-space or space-to-depth order chosen by the frame's first beat.
module pixel_shuffle_stream
  import pixel_shuffle_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int R      = 2,
  parameter int C_OUT  = 1,
  parameter int H_IN   = 2,
  parameter int W_IN   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              frame_done
);

  localparam int            N         = frame_elems(C_OUT, R, H_IN, W_IN);
  localparam int            AW        = addr_width(N);
  localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);

  state_e            state_q;
  logic              mode_q;
  logic [AW-1:0]     wcnt_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_last_q;
  logic              frame_done_q;
  logic              issued_q;

  logic [DATA_W-1:0] mem_q [N];

  logic              in_hs;
  logic              out_hs;
  logic              advance;
  logic              issue;
  logic [AW-1:0]     wr_addr;
  logic [AW-1:0]     src_addr;
  logic              src_last;

  assign in_hs   = in_valid && in_ready_q;
  assign out_hs  = out_valid_q && out_ready;
  assign advance = !out_valid_q || out_ready;
  assign issue   = (state_q == DRAIN) && advance && !issued_q;
  assign wr_addr = (state_q == FILL) ? wcnt_q : '0;

  pixel_shuffle_addr_gen #(
    .R     (R),
    .C_OUT (C_OUT),
    .H_IN  (H_IN),
    .W_IN  (W_IN),
    .AW    (AW)
  ) u_addr_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .mode_i  (mode_q),
    .clear_i (state_q != DRAIN),
    .step_i  (issue),
    .addr_o  (src_addr),
    .last_o  (src_last)
  );

  // Frame buffer contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (in_hs) begin
      mem_q[wr_addr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      mode_q       <= MODE_SHUFFLE;
      wcnt_q       <= '0;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
      issued_q     <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (in_hs) begin
            mode_q <= mode;
            if (N == 1) begin
              state_q    <= DRAIN;
              in_ready_q <= 1'b0;
              wcnt_q     <= '0;
            end else begin
              state_q <= FILL;
              wcnt_q  <= AW'(1);
            end
          end
        end

        FILL: begin
          if (in_hs) begin
            if (wcnt_q == LAST_ADDR) begin
              state_q    <= DRAIN;
              in_ready_q <= 1'b0;
              wcnt_q     <= '0;
            end else begin
              wcnt_q <= wcnt_q + AW'(1);
            end
          end
        end

        DRAIN: begin
          // The registered RAM read doubles as the one-deep output stage.
          if (issue) begin
            out_data_q  <= mem_q[src_addr];
            out_last_q  <= src_last;
            out_valid_q <= 1'b1;
            issued_q    <= src_last;
          end else if (out_hs) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
          end
          if (out_hs && out_last_q) begin
            state_q      <= IDLE;
            in_ready_q   <= 1'b1;
            frame_done_q <= 1'b1;
            issued_q     <= 1'b0;
          end
        end

        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_last   = out_last_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_pixel_shuffle_stream.sv
// Scoreboard bench: default 16-element instance and an R=3/C_OUT=2/H=2/W=3 instance.
module tb_pixel_shuffle_stream;

  localparam int DW = 8;
  localparam int RA = 2, CA = 1, HA = 2, WA = 2;
  localparam int NA = CA * RA * RA * HA * WA;
  localparam int RB = 3, CB = 2, HB = 2, WB = 3;
  localparam int NB = CB * RB * RB * HB * WB;

  typedef logic [DW-1:0] byte_t;
  typedef struct {
    byte_t d;
    bit    last;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  always #5 clk = ~clk;

  logic  a_mode, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last, a_frame_done;
  byte_t a_in_data, a_out_data;
  logic  b_mode, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last, b_frame_done;
  byte_t b_in_data, b_out_data;

  pixel_shuffle_stream #(.DATA_W(DW), .R(RA), .C_OUT(CA), .H_IN(HA), .W_IN(WA)) dut_a (
    .clk(clk), .rst_n(rst_n), .mode(a_mode), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_last(a_out_last), .frame_done(a_frame_done)
  );

  pixel_shuffle_stream #(.DATA_W(DW), .R(RB), .C_OUT(CB), .H_IN(HB), .W_IN(WB)) dut_b (
    .clk(clk), .rst_n(rst_n), .mode(b_mode), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_last(b_out_last), .frame_done(b_frame_done)
  );

  exp_t  q_a[$];
  exp_t  q_b[$];
  exp_t  ea, eb;
  int    n_cmp = 0;
  int    n_err = 0;
  bit    a_hold = 0, a_rand = 0, b_rand = 0;
  bit    a_stall = 0, b_stall = 0, a_done_exp = 0, b_done_exp = 0;
  byte_t a_pd, b_pd;
  bit    a_pl, b_pl;

  function automatic void chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Reference mapping from output position to input position, straight from the tensor indices.
  function automatic int src_idx(input int r, input int c, input int h, input int w,
                                 input bit m, input int o);
    int rr, wo, ho, x, y, ch, ww, hh, cc;
    rr = r * r;
    if (!m) begin
      wo = w * r; ho = h * r;
      x  = o % wo; y = (o / wo) % ho; ch = o / (wo * ho);
      return ((ch * rr + (y % r) * r + (x % r)) * h + y / r) * w + x / r;
    end
    ww = o % w; hh = (o / w) % h; cc = o / (w * h);
    return ((cc / rr) * h * r + hh * r + (cc % rr) / r) * (w * r) + ww * r + (cc % r);
  endfunction

  task automatic permute(input bit sel_b, input bit m, input byte_t d[$], output byte_t p[$]);
    int n;
    n = sel_b ? NB : NA;
    p = {};
    for (int o = 0; o < n; o++) begin
      if (sel_b) p.push_back(d[src_idx(RB, CB, HB, WB, m, o)]);
      else       p.push_back(d[src_idx(RA, CA, HA, WA, m, o)]);
    end
  endtask

  task automatic push_exp(input bit sel_b, input byte_t p[$]);
    exp_t e;
    for (int o = 0; o < p.size(); o++) begin
      e.d = p[o];
      e.last = (o == p.size() - 1);
      if (sel_b) q_b.push_back(e); else q_a.push_back(e);
    end
  endtask

  task automatic rand_data(input int n, output byte_t d[$]);
    d = {};
    for (int k = 0; k < n; k++) d.push_back(byte_t'($urandom_range(0, 255)));
  endtask

  // Called at posedge+1; returns at posedge+1 after the last accepted beat.
  task automatic send_frame(input bit sel_b, input bit m, input byte_t d[$], input int nbeats,
                            input int flip_at, input bit gaps);
    bit acc;
    int guard;
    for (int k = 0; k < nbeats; k++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        if (sel_b) b_in_valid = 1'b0; else a_in_valid = 1'b0;
        @(posedge clk); #1;
      end
      if (sel_b) begin
        b_in_valid = 1'b1; b_in_data = d[k]; b_mode = (k >= flip_at) ? ~m : m;
      end else begin
        a_in_valid = 1'b1; a_in_data = d[k]; a_mode = (k >= flip_at) ? ~m : m;
      end
      acc = 1'b0;
      guard = 0;
      while (!acc) begin
        @(negedge clk);
        acc = sel_b ? b_in_ready : a_in_ready;
        @(posedge clk); #1;
        guard++;
        if (!acc && guard > 300) begin
          chk("in_ready_timeout", 0, 1);
          break;
        end
      end
    end
    if (sel_b) b_in_valid = 1'b0; else a_in_valid = 1'b0;
  endtask

  task automatic wait_drain(input bit sel_b);
    int guard;
    guard = 0;
    while ((sel_b ? q_b.size() : q_a.size()) != 0) begin
      @(posedge clk);
      guard++;
      if (guard > 3000) begin
        chk(sel_b ? "b_drain_timeout" : "a_drain_timeout", sel_b ? q_b.size() : q_a.size(), 0);
        break;
      end
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    a_out_ready = 1'b1;
    b_out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      a_out_ready = !a_hold && (!a_rand || $urandom_range(0, 1) == 1);
      b_out_ready = !b_rand || $urandom_range(0, 3) != 0;
    end
  end

  // Monitor: pops the scoreboard on every output handshake, checks stall stability and frame_done.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("a_rst_in_ready", a_in_ready, 0);
      chk("a_rst_out_valid", a_out_valid, 0);
      chk("a_rst_out_data", a_out_data, 0);
      chk("a_rst_out_last", a_out_last, 0);
      chk("a_rst_frame_done", a_frame_done, 0);
      chk("b_rst_in_ready", b_in_ready, 0);
      chk("b_rst_out_valid", b_out_valid, 0);
      a_stall = 0; b_stall = 0; a_done_exp = 0; b_done_exp = 0;
    end else begin
      chk("a_frame_done", a_frame_done, a_done_exp);
      a_done_exp = 0;
      if (a_stall) begin
        chk("a_hold_valid", a_out_valid, 1);
        chk("a_hold_data", a_out_data, a_pd);
        chk("a_hold_last", a_out_last, a_pl);
      end
      if (a_out_valid) begin
        chk("a_in_ready_drain", a_in_ready, 0);
        if (a_out_ready) begin
          if (q_a.size() == 0) chk("a_unexpected_out", a_out_data, -1);
          else begin
            ea = q_a.pop_front();
            chk("a_data", a_out_data, ea.d);
            chk("a_last", a_out_last, ea.last);
          end
          a_done_exp = a_out_last;
        end
      end
      a_stall = a_out_valid && !a_out_ready; a_pd = a_out_data; a_pl = a_out_last;

      chk("b_frame_done", b_frame_done, b_done_exp);
      b_done_exp = 0;
      if (b_stall) begin
        chk("b_hold_valid", b_out_valid, 1);
        chk("b_hold_data", b_out_data, b_pd);
        chk("b_hold_last", b_out_last, b_pl);
      end
      if (b_out_valid) begin
        chk("b_in_ready_drain", b_in_ready, 0);
        if (b_out_ready) begin
          if (q_b.size() == 0) chk("b_unexpected_out", b_out_data, -1);
          else begin
            eb = q_b.pop_front();
            chk("b_data", b_out_data, eb.d);
            chk("b_last", b_out_last, eb.last);
          end
          b_done_exp = b_out_last;
        end
      end
      b_stall = b_out_valid && !b_out_ready; b_pd = b_out_data; b_pl = b_out_last;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    byte_t d[$], p[$], s[$];
    int    t2[16] = '{0, 4, 1, 5, 8, 12, 9, 13, 2, 6, 3, 7, 10, 14, 11, 15};
    a_mode = 0; a_in_valid = 0; a_in_data = '0;
    b_mode = 0; b_in_valid = 0; b_in_data = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: shuffle of 0..15
    d = {};
    for (int k = 0; k < NA; k++) d.push_back(byte_t'(k));
    permute(0, 0, d, p); push_exp(0, p);
    send_frame(0, 0, d, NA, NA, 0);
    wait_drain(0);

    // 2: unshuffle restores raster order
    d = {};
    for (int k = 0; k < NA; k++) d.push_back(byte_t'(t2[k]));
    permute(0, 1, d, p); push_exp(0, p);
    send_frame(0, 1, d, NA, NA, 0);
    wait_drain(0);

    // 3: random back-pressure plus a 5-cycle stall
    d = {};
    for (int k = 0; k < NA; k++) d.push_back(byte_t'(k));
    permute(0, 0, d, p); push_exp(0, p);
    a_rand = 1;
    fork
      send_frame(0, 0, d, NA, NA, 0);
      begin
        int g;
        g = 0;
        while (!a_out_valid && g < 300) begin @(posedge clk); g++; end
        repeat (3) @(posedge clk);
        #1 a_hold = 1;
        repeat (5) @(posedge clk);
        #1 a_hold = 0;
      end
    join
    wait_drain(0);
    a_rand = 0;

    // 4: abort after 7 beats, then a clean frame of 100..115
    d = {};
    for (int k = 0; k < NA; k++) d.push_back(byte_t'(200 + k));
    send_frame(0, 0, d, 7, NA, 0);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    d = {};
    for (int k = 0; k < NA; k++) d.push_back(byte_t'(100 + k));
    permute(0, 0, d, p); push_exp(0, p);
    send_frame(0, 0, d, NA, NA, 0);
    wait_drain(0);

    // 5: larger geometry, both modes, then shuffle->unshuffle round trip
    b_rand = 1;
    rand_data(NB, d); permute(1, 0, d, p); push_exp(1, p);
    send_frame(1, 0, d, NB, NB, 1);
    wait_drain(1);
    rand_data(NB, d); permute(1, 1, d, p); push_exp(1, p);
    send_frame(1, 1, d, NB, NB, 1);
    wait_drain(1);
    rand_data(NB, d); permute(1, 0, d, s); push_exp(1, s);
    send_frame(1, 0, d, NB, NB, 0);
    wait_drain(1);
    push_exp(1, d);
    send_frame(1, 1, s, NB, NB, 1);
    wait_drain(1);
    b_rand = 0;

    // 6: mode toggled mid-fill is ignored; following frame honours mode=1
    rand_data(NA, d); permute(0, 0, d, p); push_exp(0, p);
    send_frame(0, 0, d, NA, 3, 0);
    wait_drain(0);
    rand_data(NA, d); permute(0, 1, d, p); push_exp(0, p);
    send_frame(0, 1, d, NA, NA, 0);
    wait_drain(0);

    chk("a_scoreboard_empty", q_a.size(), 0);
    chk("b_scoreboard_empty", q_b.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
